// File: rtl/add_accumulator_pkg.sv
// Shared types and defaults for the streaming add accumulator.
package add_accumulator_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 32;
    localparam int unsigned DEFAULT_COUNT_W = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StHold  = 2'd2
    } state_e;

endpackage

// File: rtl/add_accumulator_ripple_carry_adder.sv
// Plain ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module ripple_carry_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] Number1_i,
    input  logic [WIDTH-1:0] Number2_i,
    input  logic             Carry_i,
    output logic [WIDTH-1:0] Result_o,
    output logic             Carry_o
);

    logic carry;

    always_comb begin
        Result_o = '0;
        carry    = Carry_i;
        for (int i = 0; i < int'(WIDTH); i++) begin
            Result_o[i] = Number1_i[i] ^ Number2_i[i] ^ carry;
            carry       = (Number1_i[i] & Number2_i[i]) | (carry & (Number1_i[i] ^ Number2_i[i]));
        end
        Carry_o = carry;
    end

endmodule

// File: rtl/add_accumulator.sv
// Accumulates a stream of operands into a running sum, then holds the result until taken.
module add_accumulator
    import add_accumulator_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned COUNT_W = DEFAULT_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Valid_i,
    output logic               Ready_o,
    input  logic [WIDTH-1:0]   Number_i,
    input  logic               Last_i,
    input  logic               Clear_i,
    output logic [WIDTH-1:0]   Result_o,
    output logic               Carry_o,
    output logic               ResultValid_o,
    input  logic               ResultReady_i,
    output logic [COUNT_W-1:0] Count_o
);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     acc_q, acc_d;
    logic                 carry_q, carry_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]     sum;
    logic                 sum_carry;
    logic                 accept;

    ripple_carry_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .Number1_i (acc_q),
        .Number2_i (Number_i),
        .Carry_i   (1'b0),
        .Result_o  (sum),
        .Carry_o   (sum_carry)
    );

    assign Ready_o       = (state_q != StHold);
    assign ResultValid_o = (state_q == StHold);
    assign Result_o      = acc_q;
    assign Carry_o       = carry_q;
    assign Count_o       = count_q;
    assign accept        = Valid_i & Ready_o;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        count_d = count_q;
        unique case (state_q)
            StIdle, StAccum: begin
                if (accept) begin
                    // A clear alongside a beat restarts the sum from that beat alone.
                    if (Clear_i) begin
                        acc_d   = Number_i;
                        carry_d = 1'b0;
                        count_d = COUNT_W'(1);
                    end else begin
                        acc_d   = sum;
                        carry_d = carry_q | sum_carry;
                        count_d = (&count_q) ? count_q : count_q + COUNT_W'(1);
                    end
                    state_d = Last_i ? StHold : StAccum;
                end else if (Clear_i) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (ResultReady_i) begin
                    acc_d   = '0;
                    carry_d = 1'b0;
                    count_d = '0;
                    state_d = StIdle;
                end
            end
            default: begin
                acc_d   = '0;
                carry_d = 1'b0;
                count_d = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            count_q <= count_d;
        end
    end

endmodule

// File: doc/add_accumulator.md
ADD_ACCUMULATOR -- requirements
Module: add_accumulator

Interface
REQ-001 Parameter WIDTH, default 32, sets the operand and sum width.
REQ-002 Parameter COUNT_W, default 8, sets the beat-counter width.
REQ-003 The block SHALL use the ports: clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 Valid_i  in  1  input beat valid.
REQ-006 Ready_o  out  1  block accepts a beat this cycle.
REQ-007 Number_i  in  WIDTH  operand to add into the running sum.
REQ-008 Last_i  in  1  qualifies the final beat of a sum, sampled with Valid_i.
REQ-009 Clear_i  in  1  discard the running sum.
REQ-010 Result_o  out  WIDTH  completed sum.
REQ-011 Carry_o  out  1  sticky carry-out, set if any addition in this sum overflowed.
REQ-012 ResultValid_o  out  1  Result_o, Carry_o and Count_o hold a completed sum.
REQ-013 ResultReady_i  in  1  consumer takes the result.
REQ-014 Count_o  out  COUNT_W  beats accumulated into the current or held sum.

Function
REQ-015 The block SHALL have three states: IDLE (sum empty), ACCUM (at least one beat taken), HOLD (result presented).
REQ-016 A beat SHALL be accepted on a rising edge where Valid_i=1 and Ready_o=1.
REQ-017 Ready_o SHALL be 1 in IDLE and ACCUM and 0 in HOLD.
REQ-018 On each accepted beat, acc SHALL become (acc + Number_i + 0) mod 2^WIDTH, with Carry_i tied to 0.
REQ-019 On each accepted beat, sticky carry SHALL be ORed with the adder carry-out.
REQ-020 On each accepted beat, count SHALL increment and saturate at 2^COUNT_W-1.
REQ-021 IDLE SHALL go to ACCUM on an accepted beat with Last_i=0.
REQ-022 IDLE or ACCUM SHALL go to HOLD on an accepted beat with Last_i=1.
REQ-023 Latency: ResultValid_o SHALL assert the cycle after the Last beat is accepted, with Result_o equal to the full sum including that beat.
REQ-024 In HOLD, Result_o, Carry_o and Count_o SHALL stay stable until ResultValid_o=1 and ResultReady_i=1 on an edge.
REQ-025 On that handshake edge the block SHALL go to IDLE with acc, sticky carry and count set to 0.
REQ-026 Ready_o SHALL stay 0 on the handshake edge; no same-cycle bypass.
REQ-027 Clear_i=1 in IDLE or ACCUM without an accepted beat SHALL set acc, carry and count to 0 and go to IDLE.
REQ-028 Clear_i=1 with an accepted beat in the same cycle SHALL restart the sum from that beat alone.
REQ-029 Restart values SHALL be acc=Number_i, carry=0, count=1, with the next state given by Last_i.
REQ-030 Clear_i SHALL be ignored in HOLD.
REQ-031 Valid_i=1 while Ready_o=0 SHALL have no effect; the producer holds Number_i and Last_i stable.
REQ-032 Wrap-around SHALL be silent apart from Carry_o; there is no saturation of the sum.
REQ-033 The single-beat case (first beat with Last_i=1) SHALL give HOLD with Result_o=Number_i, Carry_o=0 and Count_o=1.

Reset
REQ-034 While rst_n=0 the state SHALL be IDLE regardless of clk.
REQ-035 While rst_n=0, Ready_o SHALL be 1 and all other outputs 0 (ResultValid_o, Result_o, Carry_o, Count_o).
REQ-036 Reset asserted mid-sum or in HOLD SHALL discard the sum; no result is produced after reset is released.
REQ-037 The first beat SHALL be accepted on the first rising edge after rst_n goes high.

Structure
REQ-038 A shared package SHALL hold the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and the default WIDTH and COUNT_W.
REQ-039 The block SHALL instantiate the existing ripple_carry_adder once, WIDTH passed through, with Number1_i=acc, Number2_i=Number_i, Carry_i=0.
REQ-040 The block SHALL contain no other adder for the sum.
REQ-041 The beat counter SHALL be an ordinary incrementer, separate from the datapath adder.

Verification
REQ-042 The bench SHALL cover: beats 5, 7, 9 (Last on 9) -> after one cycle ResultValid_o=1, Result_o=21, Carry_o=0, Count_o=3.
REQ-043 The bench SHALL cover: 32'hFFFFFFFF then 1 with Last -> Result_o=0, Carry_o=1, Count_o=2.
REQ-044 The bench SHALL cover: a held result with ResultReady_i=0 for 4 cycles and Valid_i=1 -> Ready_o=0, outputs stable, no beat taken.
REQ-045 The bench SHALL then raise ResultReady_i -> the block goes to IDLE on the next edge.
REQ-046 The bench SHALL cover: beats 3, 4, then Clear_i together with beat 10 (Last) -> Result_o=10, Count_o=1.
REQ-047 The bench SHALL cover: reset pulsed after two beats -> IDLE, outputs 0, the next sum starts clean.
REQ-048 The bench SHALL cover: 300 beats of 1 with COUNT_W=8 -> Count_o=255 (saturated), Result_o=300.
